// File: rtl/video_timing_aligner.sv
// video_timing_aligner
//
// Programmable video timing generator with a sync alignment delay line.
// - Counts h/v positions and issues read requests (req_vs_n, req_de) to the frame buffer.
// - Delays hs/vs/de by DATA_LAT clocks plus one output register, so they line up with the
//   pixels the frame buffer returns.
// - Expands RGB565 to RGB888, blanks the output outside valid pixels, and keeps a sticky
//   underrun flag.
// - Region order on both axes is sync, back porch, active, front porch.
// - Frames are always run to completion before the generator goes idle.
//
// Optional build macro TIMING_ALIGNER_TEST_PATTERN_EN adds the tp_sel input. With
// tp_sel=1 the output shows 8 vertical colour bars in place of pix_in, and underrun
// detection is suppressed.
//
// Ports:
//   video_clk, rst_n    pixel clock, asynchronous active-low reset
//   enable              level-sensitive run request
//   clr_err             clears the sticky underrun flag
//   req_vs_n, req_de    frame-buffer requests (vs always active-low)
//   pix_in_de, pix_in   returned pixel valid / RGB565 data
//   out_hs/out_vs/out_de, out_r/out_g/out_b   aligned video to the DVI transmitter
//   active_x, active_y  pixel/line index, valid while req_de=1
//   frame_start         one-clock pulse at h=0, v=0
//   underrun            sticky: delayed de=1 while pix_in_de=0
//   tp_sel              (test pattern build only) select colour bars
module video_timing_aligner #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned DATA_LAT = 5,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_err,
  output logic             req_vs_n,
  output logic             req_de,
  input  logic             pix_in_de,
  input  logic [15:0]      pix_in,
  output logic             out_hs,
  output logic             out_vs,
  output logic             out_de,
  output logic [7:0]       out_r,
  output logic [7:0]       out_g,
  output logic [7:0]       out_b,
  output logic [CNT_W-1:0] active_x,
  output logic [CNT_W-1:0] active_y,
  output logic             frame_start,
  output logic             underrun
`ifdef TIMING_ALIGNER_TEST_PATTERN_EN
  ,
  input  logic             tp_sel
`endif
);

  localparam int unsigned HTotal = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VTotal = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] HLast     = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast     = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HActStart = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] HActEnd   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] VActStart = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] VActEnd   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // Request stage, one clock behind the counters
  logic             hs_raw_q, hs_raw_d;
  logic             vs_raw_q, vs_raw_d;
  logic             req_de_q, req_de_d;
  logic [CNT_W-1:0] active_x_q, active_x_d;
  logic [CNT_W-1:0] active_y_q, active_y_d;
  logic             frame_start_q, frame_start_d;

  // Alignment delay line; bit DATA_LAT-1 is the oldest entry
  logic [DATA_LAT-1:0] hs_dly_q, hs_dly_d;
  logic [DATA_LAT-1:0] vs_dly_q, vs_dly_d;
  logic [DATA_LAT-1:0] de_dly_q, de_dly_d;

  // Output stage
  logic       out_hs_q, out_hs_d;
  logic       out_vs_q, out_vs_d;
  logic       out_de_q, out_de_d;
  logic [7:0] out_r_q, out_r_d;
  logic [7:0] out_g_q, out_g_d;
  logic [7:0] out_b_q, out_b_d;
  logic       underrun_q, underrun_d;

  logic running, h_wrap, v_wrap, h_in, v_in;
  logic de_late, pix_ok, ur_set;

  // Counter FSM
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_wrap  = (h_cnt_q == HLast);
    v_wrap  = (v_cnt_q == VLast);
    unique case (state_q)
      StIdle: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) state_d = StRun;
      end
      StRun, StStopping: begin
        if (h_wrap) begin
          h_cnt_d = '0;
          v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
        if (state_q == StRun) begin
          if (!enable) state_d = StStopping;
        end else if (enable) begin
          state_d = StRun;
        end else if (h_wrap && v_wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request decode from the current counter position
  always_comb begin
    running       = (state_q != StIdle);
    h_in          = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
    v_in          = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
    hs_raw_d      = running && (h_cnt_q < HSyncEnd);
    vs_raw_d      = running && (v_cnt_q < VSyncEnd);
    req_de_d      = running && h_in && v_in;
    active_x_d    = req_de_d ? h_cnt_q - HActStart : '0;
    active_y_d    = req_de_d ? v_cnt_q - VActStart : '0;
    frame_start_d = running && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

`ifdef TIMING_ALIGNER_TEST_PATTERN_EN
  localparam int unsigned     BarWInt = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CNT_W-1:0] BarW   = CNT_W'(BarWInt);

  logic [CNT_W-1:0] x_dly_q [DATA_LAT];
  logic [CNT_W-1:0] x_dly_d [DATA_LAT];
  logic [CNT_W-1:0] bar_idx;
  logic [23:0]      bar_rgb;

  always_comb begin
    x_dly_d[0] = active_x_q;
    for (int unsigned i = 1; i < DATA_LAT; i++) x_dly_d[i] = x_dly_q[i-1];
    bar_idx = x_dly_q[DATA_LAT-1] / BarW;
    // White, yellow, cyan, green, magenta, red, blue, black: each channel is one
    // inverted bit of the bar index (R=~i[1], G=~i[2], B=~i[0]).
    if (bar_idx < CNT_W'(8)) begin
      bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    end else begin
      bar_rgb = 24'h000000;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DATA_LAT; i++) x_dly_q[i] <= '0;
    end else begin
      x_dly_q <= x_dly_d;
    end
  end
`endif

  // Delay line and output stage
  always_comb begin
    hs_dly_d = (hs_dly_q << 1) | DATA_LAT'(hs_raw_q);
    vs_dly_d = (vs_dly_q << 1) | DATA_LAT'(vs_raw_q);
    de_dly_d = (de_dly_q << 1) | DATA_LAT'(req_de_q);
    de_late  = de_dly_q[DATA_LAT-1];
    out_hs_d = hs_dly_q[DATA_LAT-1] ~^ HS_POL;
    out_vs_d = vs_dly_q[DATA_LAT-1] ~^ VS_POL;
    out_de_d = de_late;
    pix_ok   = de_late & pix_in_de;
    out_r_d  = pix_ok ? {pix_in[15:11], pix_in[15:13]} : 8'h00;
    out_g_d  = pix_ok ? {pix_in[10:5], pix_in[10:9]} : 8'h00;
    out_b_d  = pix_ok ? {pix_in[4:0], pix_in[4:2]} : 8'h00;
    ur_set   = de_late & ~pix_in_de;
`ifdef TIMING_ALIGNER_TEST_PATTERN_EN
    if (tp_sel) begin
      {out_r_d, out_g_d, out_b_d} = de_late ? bar_rgb : 24'h000000;
      ur_set = 1'b0;
    end
`endif
    // A new underrun in the same clock as clr_err keeps the flag set
    underrun_d = ur_set | (underrun_q & ~clr_err);
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_raw_q      <= 1'b0;
      vs_raw_q      <= 1'b0;
      req_de_q      <= 1'b0;
      active_x_q    <= '0;
      active_y_q    <= '0;
      frame_start_q <= 1'b0;
      hs_dly_q      <= '0;
      vs_dly_q      <= '0;
      de_dly_q      <= '0;
      out_hs_q      <= ~HS_POL;
      out_vs_q      <= ~VS_POL;
      out_de_q      <= 1'b0;
      out_r_q       <= 8'h00;
      out_g_q       <= 8'h00;
      out_b_q       <= 8'h00;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      req_de_q      <= req_de_d;
      active_x_q    <= active_x_d;
      active_y_q    <= active_y_d;
      frame_start_q <= frame_start_d;
      hs_dly_q      <= hs_dly_d;
      vs_dly_q      <= vs_dly_d;
      de_dly_q      <= de_dly_d;
      out_hs_q      <= out_hs_d;
      out_vs_q      <= out_vs_d;
      out_de_q      <= out_de_d;
      out_r_q       <= out_r_d;
      out_g_q       <= out_g_d;
      out_b_q       <= out_b_d;
      underrun_q    <= underrun_d;
    end
  end

  assign req_vs_n    = ~vs_raw_q;
  assign req_de      = req_de_q;
  assign active_x    = active_x_q;
  assign active_y    = active_y_q;
  assign frame_start = frame_start_q;
  assign out_hs      = out_hs_q;
  assign out_vs      = out_vs_q;
  assign out_de      = out_de_q;
  assign out_r       = out_r_q;
  assign out_g       = out_g_q;
  assign out_b       = out_b_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_video_timing_aligner.sv
// Testbench for video_timing_aligner: small 14x7 timing, DATA_LAT=5. A second instance with
// negative sync polarity shares all inputs. A frame-position reference model with a
// request-history queue predicts every output each clock. Directed sequences and a
// conversion table cover the corner cases.
module tb_video_timing_aligner;

  localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int LAT = 5, CW = 12;
  localparam int HT = HSW + HBP + HA + HFP;
  localparam int VT = VSW + VBP + VA + VFP;
  localparam int FRAME = HT * VT;
  localparam int DE_H0 = HSW + HBP, DE_V0 = VSW + VBP;

  logic video_clk = 1'b0;
  logic rst_n, enable, clr_err, pix_in_de, tp_sel;
  logic [15:0] pix_in;
  logic req_vs_n, req_de, out_hs, out_vs, out_de, frame_start, underrun;
  logic [7:0] out_r, out_g, out_b;
  logic [CW-1:0] active_x, active_y;
  logic b_req_vs_n, b_req_de, b_out_hs, b_out_vs, b_out_de, b_frame_start, b_underrun;
  logic [7:0] b_out_r, b_out_g, b_out_b;
  logic [CW-1:0] b_active_x, b_active_y;

  always #5 video_clk = ~video_clk;

  video_timing_aligner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .DATA_LAT(LAT), .CNT_W(CW)
  ) u_dut (
    .video_clk(video_clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
    .req_vs_n(req_vs_n), .req_de(req_de), .pix_in_de(pix_in_de), .pix_in(pix_in),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .active_x(active_x), .active_y(active_y),
    .frame_start(frame_start), .underrun(underrun)
`ifdef TIMING_ALIGNER_TEST_PATTERN_EN
    , .tp_sel(tp_sel)
`endif
  );

  video_timing_aligner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_LAT(LAT), .CNT_W(CW)
  ) u_dut_neg (
    .video_clk(video_clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
    .req_vs_n(b_req_vs_n), .req_de(b_req_de), .pix_in_de(pix_in_de), .pix_in(pix_in),
    .out_hs(b_out_hs), .out_vs(b_out_vs), .out_de(b_out_de),
    .out_r(b_out_r), .out_g(b_out_g), .out_b(b_out_b),
    .active_x(b_active_x), .active_y(b_active_y),
    .frame_start(b_frame_start), .underrun(b_underrun)
`ifdef TIMING_ALIGNER_TEST_PATTERN_EN
    , .tp_sel(tp_sel)
`endif
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic hs; logic vs; logic de; logic fs;
    logic [CW-1:0] x; logic [CW-1:0] y;
  } req_t;

  req_t hist[$];   // request-side values, hist[0] = after the latest clock
  int m_mode;      // 0 idle, 1 run, 2 stopping
  int m_pos;       // frame position v*HT+h of the counters
  logic e_hs, e_vs, e_de, e_ur;
  logic [23:0] e_rgb;
  logic [23:0] bars [8];

  function automatic req_t req_at(input bit run, input int pos);
    req_t r;
    int h, v;
    h = pos % HT;
    v = pos / HT;
    r = '0;
    if (run) begin
      r.hs = (h < HSW);
      r.vs = (v < VSW);
      r.de = (h >= DE_H0) && (h < DE_H0 + HA) && (v >= DE_V0) && (v < DE_V0 + VA);
      r.fs = (pos == 0);
      if (r.de) begin
        r.x = CW'(h - DE_H0);
        r.y = CW'(v - DE_V0);
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r5, g6, b5;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= LAT; i++) hist.push_back('0);
    m_mode = 0; m_pos = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_ur = 0; e_rgb = '0;
  endtask

  task automatic model_step(input logic en, input logic clr, input logic pde,
                            input logic [15:0] pix, input logic tp);
    req_t late;
    bit last;
    late = hist[LAT];
    e_hs = late.hs; e_vs = late.vs; e_de = late.de;
    if (tp) begin
      e_rgb = late.de ? bars[int'(late.x) / (HA / 8)] : 24'h0;
      e_ur  = e_ur && !clr;
    end else begin
      e_rgb = (late.de && pde) ? expand(pix) : 24'h0;
      e_ur  = (late.de && !pde) || (e_ur && !clr);
    end
    hist.push_front(req_at(m_mode != 0, m_pos));
    void'(hist.pop_back());
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else begin
      last  = (m_pos == FRAME - 1);
      m_pos = (m_pos + 1) % FRAME;
      if (m_mode == 1) begin
        if (!en) m_mode = 2;
      end else if (en) m_mode = 1;
      else if (last) m_mode = 0;
    end
  endtask

  // One clock: sample inputs, advance the model, compare everything.
  task automatic tick();
    logic en, clr, pde, tp;
    logic [15:0] pix;
    en = enable; clr = clr_err; pde = pix_in_de; pix = pix_in; tp = tp_sel;
    @(posedge video_clk);
    #1;
    model_step(en, clr, pde, pix, tp);
    check("sync", {out_hs, out_vs, out_de, b_out_hs, b_out_vs}, {e_hs, e_vs, e_de, ~e_hs, ~e_vs});
    check("req", {req_de, req_vs_n, frame_start, active_x, active_y},
          {hist[0].de, ~hist[0].vs, hist[0].fs, hist[0].x, hist[0].y});
    check("rgb", {out_r, out_g, out_b}, e_rgb);
    check("underrun", underrun, e_ur);
  endtask

  // Clock, then let the source answer the request from LAT clocks ago.
  task automatic step();
    tick();
    pix_in_de = hist[LAT].de;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && !pix_in_de; i++) step();
    if (!pix_in_de) check("wait_valid_timeout", 0, 1);
  endtask

  function automatic logic [32:0] rst_vec();
    return {out_hs, out_vs, out_de, b_out_hs, b_out_vs, req_de, req_vs_n, frame_start,
            underrun, out_r, out_g, out_b};
  endfunction
  localparam logic [32:0] RstExp = {9'b000_11_0_1_0_0, 24'h0};

  typedef struct {
    logic [15:0] pix;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_hs, c_vs, c_de, c_fs, c_rise, viol, cnt;
    logic prev_hs;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    tbl[0] = '{16'hF800, 24'hFF0000};
    tbl[1] = '{16'h07E0, 24'h00FF00};
    tbl[2] = '{16'h001F, 24'h0000FF};
    tbl[3] = '{16'hFFFF, 24'hFFFFFF};
    tbl[4] = '{16'h0000, 24'h000000};
    tbl[5] = '{16'h8410, 24'h848284};
    tbl[6] = '{16'h0821, 24'h080408};
    tbl[7] = '{16'h7BEF, 24'h7B7D7B};

    rst_n = 1; enable = 0; clr_err = 0; pix_in_de = 0; pix_in = 16'hF800; tp_sel = 0;
    model_reset();
    #1 rst_n = 0;
    #1 check("reset_values", rst_vec(), RstExp);
    @(negedge video_clk);
    rst_n = 1;
    step();
    step();
    check("idle_quiet", {req_de, req_vs_n, out_de, frame_start}, 4'b0100);

    // Continuous run with a red source
    enable = 1;
    for (int i = 0; i < 2 * FRAME; i++) step();
    c_hs = 0; c_vs = 0; c_de = 0; c_fs = 0; c_rise = 0;
    prev_hs = out_hs;
    for (int i = 0; i < FRAME; i++) begin
      step();
      c_hs += int'(out_hs); c_vs += int'(out_vs); c_de += int'(out_de);
      c_fs += int'(frame_start);
      if (out_hs && !prev_hs) c_rise++;
      prev_hs = out_hs;
      if (out_de) check("red_pixel", {out_r, out_g, out_b}, 24'hFF0000);
    end
    check("hs_cycles", c_hs, 2 * VT);
    check("hs_lines", c_rise, VT);
    check("vs_cycles", c_vs, HT);
    check("de_cycles", c_de, HA * VA);
    check("frame_start_count", c_fs, 1);
    check("no_underrun", underrun, 0);

    // RGB565 expansion table
    foreach (tbl[k]) begin
      wait_valid();
      pix_in = tbl[k].pix;
      step();
      check("table_rgb", {out_de, out_r, out_g, out_b}, {1'b1, tbl[k].rgb});
    end

    // Single dropped pixel, sticky flag, clear, then set-wins
    wait_valid();
    step();
    wait_valid();
    pix_in = 16'hFFFF;
    pix_in_de = 0;
    step();
    check("drop_pixel", {out_de, out_r, out_g, out_b}, {1'b1, 24'h0});
    check("drop_underrun", underrun, 1);
    for (int i = 0; i < 3; i++) step();
    check("underrun_sticky", underrun, 1);
    clr_err = 1;
    step();
    clr_err = 0;
    check("underrun_clear", underrun, 0);
    wait_valid();
    pix_in_de = 0;
    clr_err = 1;
    step();
    clr_err = 0;
    check("underrun_set_wins", underrun, 1);
    clr_err = 1;
    step();
    clr_err = 0;

    // Stop at the start of line 2: frame completes, then idle
    for (int i = 0; i < 2 * FRAME && m_pos != 2 * HT; i++) step();
    enable = 0;
    cnt = 0; viol = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      cnt += int'(req_de);
      if (i >= 80 && (req_de || !req_vs_n || out_de || b_req_de)) viol++;
    end
    check("stop_de_count", cnt, HA * VA);
    check("stop_idle_quiet", viol, 0);

    // Restart latency
    enable = 1;
    step();
    cnt = 0;
    while (!req_de && cnt < 300) begin
      step();
      cnt++;
    end
    check("restart_latency", cnt, (VSW + VBP) * HT + HSW + HBP + 1);

    // Asynchronous reset in the middle of an active line with underrun set
    wait_valid();
    pix_in_de = 0;
    step();
    #3 rst_n = 0;
    #1 check("async_reset", rst_vec(), RstExp);
    model_reset();
    pix_in_de = 0;
    @(negedge video_clk);
    rst_n = 1;

    // Randomized traffic with enable toggling, drops and clears
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) enable = ~enable;
      pix_in = 16'($urandom);
      if (pix_in_de && $urandom_range(0, 39) == 0) pix_in_de = 0;
      clr_err = ($urandom_range(0, 49) == 0);
      step();
    end
    clr_err = 0;

`ifdef TIMING_ALIGNER_TEST_PATTERN_EN
    // Colour bars: source ignored, drops do not raise underrun
    clr_err = 1;
    step();
    clr_err = 0;
    enable = 1;
    tp_sel = 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      pix_in_de = 0;
      step();
    end
    check("tp_no_underrun", underrun, 0);
    tp_sel = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing_aligner.md
Name: video_timing_aligner

Overview:
Parametrised successor to the fixed vga_timing generator plus hand-built 7-deep sync delay line in the camera-to-HDMI top level.
- Generates programmable-resolution video timing.
- Issues negative-polarity vs and de read requests to Video_Frame_Buffer_Top.
- Delays the sync signals by a parameter latency so they align with returned pixels.
- Expands RGB565 to RGB888 with blanking, and flags underruns.
- Sits between the frame buffer and DVI_TX_Top.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, horizontal sync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width
V_BP, 20, vertical back porch
HS_POL, 1, out_hs active level (1 = positive)
VS_POL, 1, out_vs active level
DATA_LAT, 5, clocks from req_de to the matching pix_in_de/pix_in; legal range 1..31
CNT_W, 12, width of the h/v counters and of active_x/active_y

Ports:
video_clk  in  1  pixel clock
rst_n  in  1  async active-low reset
enable  in  1  run request; level-sensitive
clr_err  in  1  clears the sticky underrun flag
req_vs_n  out  1  frame-buffer vs request, always active-low
req_de  out  1  frame-buffer pixel read request
pix_in_de  in  1  pixel valid from the frame buffer
pix_in  in  16  RGB565 {r[4:0],g[5:0],b[4:0]}
out_hs  out  1  delayed hs, polarity set by HS_POL
out_vs  out  1  delayed vs, polarity set by VS_POL
out_de  out  1  delayed de
out_r  out  8  red
out_g  out  8  green
out_b  out  8  blue
active_x  out  CNT_W  pixel index, valid while req_de=1
active_y  out  CNT_W  line index, valid while req_de=1
frame_start  out  1  one-clock pulse at h=0, v=0 of each frame
underrun  out  1  sticky error flag

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL defined likewise.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Region order is sync (starting at count 0), back porch, active, front porch.
- Request outputs are registered one clock after the counters:
  - hs_raw active while h_cnt < H_SYNC.
  - vs_raw active while v_cnt < V_SYNC.
  - req_de = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - req_vs_n = ~vs_raw.
  - active_x/active_y = counter minus start offset, zero outside the active region.
- Output side: hs_raw, vs_raw and req_de pass through a DATA_LAT-deep shift register, then one further register stage.
  - out_hs, out_vs, out_de change exactly DATA_LAT+1 clocks after the corresponding req_* edge.
  - out_hs = hs_raw delayed XNOR HS_POL; out_vs is formed the same way with VS_POL.
- Pixel data is registered in the same final stage:
  - out_r = {r,r[4:2]}, out_g = {g,g[5:4]}, out_b = {b,b[4:2]}.
  - RGB is forced to 0 when delayed de=0 or pix_in_de=0.
- Underrun: set on any clock where delayed de=1 and pix_in_de=0.
  - Sticky until clr_err=1.
  - If clr_err and a new underrun occur in the same clock, set wins.
- FSM states:
  - IDLE: counters held at 0, syncs inactive, req_de=0, req_vs_n=1. enable=1 moves to RUN on the next clock, starting at h=0, v=0.
  - RUN: enable=0 moves to STOPPING.
  - STOPPING: completes the current frame, then goes to IDLE when v and h both wrap. enable=1 in STOPPING returns to RUN with no glitch.
- Frames are never truncated by enable.
- The delay line keeps shifting in IDLE, so the trailing DATA_LAT cycles of the last frame drain normally.
- Reset (async) applies these values:
  - FSM to IDLE; counters 0; shift registers 0 (de) or inactive (syncs).
  - out_de=0, RGB=0, out_hs/out_vs at inactive level, req_vs_n=1, req_de=0.
  - frame_start=0, underrun=0.
- Reset asserted mid-frame aborts the frame immediately.

Optional Feature:
TIMING_ALIGNER_TEST_PATTERN_EN
- When defined: adds input tp_sel (1 bit).
- With tp_sel=1, pix_in is ignored and underrun detection is suppressed.
- The output shows 8 vertical colour bars of width H_ACTIVE/8, indexed by delayed active_x[.]/(H_ACTIVE/8), in the order white, yellow, cyan, green, magenta, red, blue, black (8-bit full scale), gated by out_de.
- When undefined: no tp_sel port and no bar logic.

Test Plan:
1. Small timing, H 8/2/2/2, V 4/1/1/1, enable=1 -> out_hs period 14 clocks, out_vs 7 lines, out_de 8 clocks × 4 lines per frame; frame_start once per 98 clocks.
2. Source driving pix_in_de = req_de delayed DATA_LAT=5, pix_in=16'hF800 -> out_r=8'hFF, out_g=0, out_b=0, exactly aligned with out_de; no underrun.
3. Drop pix_in_de for 1 clock mid-line -> that pixel outputs 0, underrun=1 and stays set; pulse clr_err -> underrun=0 next clock.
4. Deassert enable mid-frame at v=2 -> frame completes, FSM goes to IDLE, req_vs_n stays 1; re-enable -> first req_de after exactly (V_SYNC+V_BP)*H_TOTAL+H_SYNC+H_BP+1 clocks.
5. HS_POL=0, VS_POL=0 -> syncs idle high, pulse low; assert rst_n=0 mid-line -> all outputs take reset values asynchronously.
6. With TIMING_ALIGNER_TEST_PATTERN_EN defined, tp_sel=1, H_ACTIVE=16 -> pixels 0-1 24'hFFFFFF, 2-3 24'hFFFF00, …, 14-15 24'h000000.
